target_loader: RTL and testbench
================================

Name: target_loader

Overview:
- CPU-side writer for the tracked-target slot array.
- Accepts "create target" requests over a valid/ready handshake and finds the lowest-index free slot (BUSY=0).
- Drives the array's write interface (one-hot EN_CPU, XY_CPU, WR_XY, FIRE_CPU, VISIBLE_CPU) for exactly one cycle, then waits for that slot's BUSY to rise as confirmation.
- Returns slot index and status to the CPU.

Parameters:
- WIDTH, 19, index of the highest slot; the array has WIDTH+1 slots. Legal range 0..31.
- TIMEOUT, 15, number of CONFIRM cycles allowed before BUSY[slot] must be seen high.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous reset, active-low
- REQ_VALID  in  1  create request valid
- REQ_READY  out  1  loader can accept a request
- REQ_XY  in  26  target coordinates
- REQ_FIRE  in  1  fire flag for new target
- REQ_VISIBLE  in  1  visible flag for new target
- BUSY  in  WIDTH+1  per-slot occupancy from the target array
- EN_CPU  out  WIDTH+1  one-hot slot select
- XY_CPU  out  26  coordinates to array
- WR_XY  out  1  write strobe
- FIRE_CPU  out  1  fire flag to array
- VISIBLE_CPU  out  1  visible flag to array
- ACK_VALID  out  1  one-cycle response pulse
- ACK_SLOT  out  5  slot written (0 when status is FULL)
- ACK_ERR  out  2  00=OK, 01=FULL, 10=TIMEOUT
- FREE_CNT  out  6  registered count of slots with BUSY=0

Behaviour:
- All outputs registered.
- Reset (RESET_N=0, async): state IDLE; REQ_READY=0 during reset, 1 from the first clock edge after release; EN_CPU=0, XY_CPU=0, WR_XY=0, FIRE_CPU=0, VISIBLE_CPU=0, ACK_VALID=0, ACK_SLOT=0, ACK_ERR=0, FREE_CNT=0. Reset mid-operation aborts silently with no ACK.
- FSM states: IDLE, SEARCH, WRITE, CONFIRM, RESP.
- IDLE: REQ_READY=1. On REQ_VALID&REQ_READY, latch REQ_XY/REQ_FIRE/REQ_VISIBLE, drop REQ_READY, go to SEARCH.
- SEARCH (1 cycle): priority-encode the lowest index i with BUSY[i]=0, sampled live this cycle.
  - Slot found: latch i, go to WRITE.
  - No slot: status FULL, go to RESP.
- WRITE (1 cycle): EN_CPU=1<<slot, WR_XY=1, XY_CPU/FIRE_CPU/VISIBLE_CPU = latched values. Clear the confirm counter, go to CONFIRM.
  - Latency: handshake at edge k gives WR_XY high in cycle k+2.
- CONFIRM: EN_CPU=0, WR_XY=0. XY_CPU/FIRE_CPU/VISIBLE_CPU hold their values.
  - The first CONFIRM cycle checks BUSY; the counter increments once per cycle.
  - BUSY[slot]=1: status OK, go to RESP.
  - Counter reaches TIMEOUT with BUSY still low: status TIMEOUT, go to RESP.
  - BUSY[slot] high in the same cycle the counter reaches TIMEOUT: OK wins.
- RESP (1 cycle): ACK_VALID=1 with ACK_SLOT/ACK_ERR. Go to IDLE; REQ_READY=1 on the next cycle.
  - Back-to-back requests therefore take at least 5 cycles each.
- ACK_SLOT/ACK_ERR hold their last values outside RESP.
- FREE_CNT = popcount(~BUSY), updated every cycle independent of the FSM; one cycle of latency.
- BUSY of other slots changing during CONFIRM is ignored.
- A slot freed after SEARCH reported FULL is not retried; the CPU resubmits.
- REQ_XY changes while not ready are ignored.
- Requests are never dropped once accepted: every handshake yields exactly one ACK unless reset intervenes.

Decomposition:
- Shared package targets_pkg:
  - XY_W=26
  - typedef ack_err_t enum {ERR_OK=2'b00, ERR_FULL=2'b01, ERR_TIMEOUT=2'b10}
  - typedef loader_state_t for the FSM states
  - MAX_SLOTS=32
- Sub-module target_prio_enc: combinational lowest-zero finder over WIDTH+1 bits; outputs found flag and 5-bit index.

Test Plan:
- Reset, BUSY=0, request XY=26'h0ABCDEF, FIRE=1, VIS=0 -> WR_XY high 2 cycles after handshake, EN_CPU=20'h00001, XY_CPU=26'h0ABCDEF, FIRE_CPU=1. BUSY[0] raised next cycle -> ACK_VALID pulse, ACK_SLOT=0, ACK_ERR=00.
- BUSY=20'h0000F, request -> EN_CPU=20'h00010. BUSY[4] rises 3 cycles later -> ACK_SLOT=4, OK. FREE_CNT 16 before the write, 15 after.
- BUSY=20'hFFFFF, request -> no WR_XY ever; ACK_VALID with ACK_ERR=01, ACK_SLOT=0, 2 cycles after handshake.
- BUSY=0, BUSY[0] never rises -> ACK_ERR=10 after exactly TIMEOUT=15 CONFIRM cycles. Same case with BUSY[0] rising on the 15th CONFIRM cycle -> ACK_ERR=00.
- RESET_N pulled low during CONFIRM -> all outputs 0 immediately, no ACK. After release, a new request completes normally at slot 0.
- REQ_VALID held high for 3 requests with BUSY fed back from a slot model -> slots 0,1,2 written in order. REQ_READY low between accepts, one ACK per request.

Source files
------------

// File: rtl/targets_pkg.sv
// Shared types and sizes for the tracked-target slot array and its CPU loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package targets_pkg;

    localparam int XY_W      = 26;
    localparam int MAX_SLOTS = 32;
    localparam int SLOT_W    = 5;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_FULL    = 2'b01,
        ERR_TIMEOUT = 2'b10
    } ack_err_t;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        WRITE,
        CONFIRM,
        RESP
    } loader_state_t;

endpackage

// File: rtl/target_prio_enc.sv
// Lowest-index free-slot finder: returns the lowest i with busy[i]=0.
// Latency: purely combinational.
// Backpressure: none.
// Ports: busy (N occupancy bits) -> found (any zero present), idx (lowest zero index).
module target_prio_enc
    import targets_pkg::*;
#(
    parameter int N = 20
) (
    input  logic [N-1:0]      busy,
    output logic              found,
    output logic [SLOT_W-1:0] idx
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                found = 1'b1;
                idx   = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/target_loader.sv
// CPU-side writer: accepts a create request, picks the lowest free slot, writes it, awaits BUSY.
// Latency: handshake -> WR_XY two cycles; ACK in the same cycle as RESP (FULL: two cycles).
// Backpressure: REQ_READY only in IDLE; one request in flight, no request is dropped once accepted.
// Ports: CLK/RESET_N; REQ_* request in; BUSY from the array; EN/XY/WR/FIRE/VISIBLE_CPU to array;
//        ACK_* response pulse; FREE_CNT registered count of free slots.
module target_loader
    import targets_pkg::*;
#(
    parameter int WIDTH   = 19,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [XY_W-1:0]   REQ_XY,
    input  logic              REQ_FIRE,
    input  logic              REQ_VISIBLE,
    input  logic [WIDTH:0]    BUSY,
    output logic [WIDTH:0]    EN_CPU,
    output logic [XY_W-1:0]   XY_CPU,
    output logic              WR_XY,
    output logic              FIRE_CPU,
    output logic              VISIBLE_CPU,
    output logic              ACK_VALID,
    output logic [SLOT_W-1:0] ACK_SLOT,
    output logic [1:0]        ACK_ERR,
    output logic [5:0]        FREE_CNT
);

    localparam int N     = WIDTH + 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    loader_state_t      state_q, state_nxt;
    logic [SLOT_W-1:0]  slot_q, slot_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    ack_err_t           err_nxt;
    logic               accept;
    logic [XY_W-1:0]    xy_lat;
    logic               fire_lat;
    logic               vis_lat;
    logic               enc_found;
    logic [SLOT_W-1:0]  enc_idx;
    logic               slot_hit;
    logic [5:0]         free_nxt;

    target_prio_enc #(.N(N)) u_prio_enc (
        .busy  (BUSY),
        .found (enc_found),
        .idx   (enc_idx)
    );

    // Only the slot we wrote can confirm; other BUSY bits are ignored here.
    assign slot_hit = |(BUSY & (N'(1) << slot_q));

    always_comb begin
        free_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (!BUSY[i]) free_nxt = free_nxt + 6'd1;
        end
    end

    always_comb begin
        state_nxt = state_q;
        slot_nxt  = slot_q;
        cnt_nxt   = cnt_q;
        err_nxt   = ERR_OK;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    accept    = 1'b1;
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (enc_found) begin
                    slot_nxt  = enc_idx;
                    state_nxt = WRITE;
                end else begin
                    // FULL reports slot 0; a slot freed later is not retried.
                    slot_nxt  = '0;
                    err_nxt   = ERR_FULL;
                    state_nxt = RESP;
                end
            end
            WRITE: begin
                cnt_nxt   = '0;
                state_nxt = CONFIRM;
            end
            CONFIRM: begin
                // BUSY is tested before the timeout so a same-cycle confirm wins.
                if (slot_hit) begin
                    err_nxt   = ERR_OK;
                    state_nxt = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            cnt_q       <= '0;
            xy_lat      <= '0;
            fire_lat    <= 1'b0;
            vis_lat     <= 1'b0;
            REQ_READY   <= 1'b0;
            EN_CPU      <= '0;
            XY_CPU      <= '0;
            WR_XY       <= 1'b0;
            FIRE_CPU    <= 1'b0;
            VISIBLE_CPU <= 1'b0;
            ACK_VALID   <= 1'b0;
            ACK_SLOT    <= '0;
            ACK_ERR     <= '0;
            FREE_CNT    <= '0;
        end else begin
            state_q   <= state_nxt;
            slot_q    <= slot_nxt;
            cnt_q     <= cnt_nxt;
            if (accept) begin
                xy_lat   <= REQ_XY;
                fire_lat <= REQ_FIRE;
                vis_lat  <= REQ_VISIBLE;
            end
            REQ_READY <= (state_nxt == IDLE);
            WR_XY     <= (state_nxt == WRITE);
            EN_CPU    <= (state_nxt == WRITE) ? (N'(1) << slot_nxt) : '0;
            if (state_nxt == WRITE) begin
                XY_CPU      <= xy_lat;
                FIRE_CPU    <= fire_lat;
                VISIBLE_CPU <= vis_lat;
            end
            ACK_VALID <= (state_nxt == RESP);
            if (state_nxt == RESP) begin
                ACK_SLOT <= slot_nxt;
                ACK_ERR  <= err_nxt;
            end
            FREE_CNT  <= free_nxt;
        end
    end

endmodule

// File: tb/tb_target_loader.sv
// Bench for target_loader: scoreboard of expected writes/acks, BUSY feedback model.
// Latency: checks handshake->write and handshake->ack cycle counts.
// Backpressure: requests wait for REQ_READY; REQ_VALID held high in the streaming case.
module tb_target_loader;
    import targets_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [25:0] req_xy;
    logic        req_fire;
    logic        req_visible;
    logic [19:0] busy_stim;
    logic [19:0] fb_busy;
    logic [19:0] busy_all;
    logic [19:0] en_cpu;
    logic [25:0] xy_cpu;
    logic        wr_xy;
    logic        fire_cpu;
    logic        visible_cpu;
    logic        ack_valid;
    logic [4:0]  ack_slot;
    logic [1:0]  ack_err;
    logic [5:0]  free_cnt;

    assign busy_all = busy_stim | fb_busy;

    target_loader #(.WIDTH(19), .TIMEOUT(15)) dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .REQ_VALID   (req_valid),
        .REQ_READY   (req_ready),
        .REQ_XY      (req_xy),
        .REQ_FIRE    (req_fire),
        .REQ_VISIBLE (req_visible),
        .BUSY        (busy_all),
        .EN_CPU      (en_cpu),
        .XY_CPU      (xy_cpu),
        .WR_XY       (wr_xy),
        .FIRE_CPU    (fire_cpu),
        .VISIBLE_CPU (visible_cpu),
        .ACK_VALID   (ack_valid),
        .ACK_SLOT    (ack_slot),
        .ACK_ERR     (ack_err),
        .FREE_CNT    (free_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  slot;
        logic [1:0]  err;
        int          lat;
        logic [25:0] xy;
        logic        fire;
        logic        vis;
    } exp_t;

    exp_t exp_q[$];
    int   hs_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ncyc     = 0;
    int   hs_total = 0;
    int   ack_total = 0;
    int   fb_delay = 0;
    int   fb_at    = -1;
    logic [4:0] fb_slot = '0;
    int   epoch    = 0;
    int   seen_epoch = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: samples on the falling edge, compares against the scoreboard, models BUSY feedback.
    initial fb_busy = '0;
    always @(negedge clk) begin
        logic [19:0] exp_en;
        ncyc++;
        if (epoch != seen_epoch) begin
            fb_busy    = '0;
            fb_at      = -1;
            seen_epoch = epoch;
        end
        if (!rst_n) begin
            exp_q.delete();
            hs_q.delete();
            fb_at = -1;
        end else begin
            if (req_valid && req_ready) begin
                hs_q.push_back(ncyc);
                hs_total++;
            end
            if (wr_xy) begin
                if (exp_q.size() == 0 || hs_q.size() == 0 || exp_q[0].err == ERR_FULL) begin
                    chk_eq("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_en = 20'd1 << exp_q[0].slot;
                    chk_eq("wr_lat", ncyc - hs_q[0], 32'd2);
                    chk_eq("wr_en", en_cpu, exp_en);
                    chk_eq("wr_xy", xy_cpu, exp_q[0].xy);
                    chk_eq("wr_fire", fire_cpu, exp_q[0].fire);
                    chk_eq("wr_vis", visible_cpu, exp_q[0].vis);
                    if (fb_delay > 0) begin
                        fb_at   = ncyc + fb_delay;
                        fb_slot = exp_q[0].slot;
                    end
                end
            end else if (en_cpu != '0) begin
                chk_eq("en_without_wr", en_cpu, 32'd0);
            end
            if (ack_valid) begin
                ack_total++;
                if (exp_q.size() == 0 || hs_q.size() == 0) begin
                    chk_eq("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    chk_eq("ack_slot", ack_slot, exp_q[0].slot);
                    chk_eq("ack_err", ack_err, exp_q[0].err);
                    chk_eq("ack_lat", ncyc - hs_q[0], exp_q[0].lat);
                    void'(exp_q.pop_front());
                    void'(hs_q.pop_front());
                end
            end
            if (ncyc == fb_at) fb_busy[fb_slot] = 1'b1;
        end
    end

    task automatic send(input logic [25:0] xy, input logic fire, input logic vis,
                        input logic [4:0] slot, input logic [1:0] err, input int lat);
        exp_t e;
        logic was_rdy;
        int   n;
        e.slot = slot; e.err = err; e.lat = lat; e.xy = xy; e.fire = fire; e.vis = vis;
        exp_q.push_back(e);
        req_valid   = 1'b1;
        req_xy      = xy;
        req_fire    = fire;
        req_visible = vis;
        n = 0;
        was_rdy = 1'b0;
        while (!was_rdy && n < 50) begin
            was_rdy = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk_eq("send_accepted", was_rdy, 1'b1);
        req_valid   = 1'b0;
        // Post-accept changes must not reach the array.
        req_xy      = ~xy;
        req_fire    = ~fire;
        req_visible = ~vis;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk_eq(tag, exp_q.size(), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_ready"}, req_ready, 32'd0);
        chk_eq({tag, "_en"}, en_cpu, 32'd0);
        chk_eq({tag, "_xy"}, xy_cpu, 32'd0);
        chk_eq({tag, "_wr"}, wr_xy, 32'd0);
        chk_eq({tag, "_fire"}, fire_cpu, 32'd0);
        chk_eq({tag, "_vis"}, visible_cpu, 32'd0);
        chk_eq({tag, "_ackv"}, ack_valid, 32'd0);
        chk_eq({tag, "_acks"}, ack_slot, 32'd0);
        chk_eq({tag, "_acke"}, ack_err, 32'd0);
        chk_eq({tag, "_free"}, free_cnt, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int ready_hi;
        int n;
        int acks_before;
        rst_n = 1'b0; req_valid = 1'b0; req_xy = '0; req_fire = 1'b0; req_visible = 1'b0;
        busy_stim = '0;

        // Reset state
        #3;
        chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_eq("ready_before_edge", req_ready, 32'd0);
        @(posedge clk); #1;
        chk_eq("ready_after_edge", req_ready, 32'd1);

        // Basic write to slot 0, BUSY confirms on the first CONFIRM cycle
        fb_delay = 1;
        send(26'h0ABCDEF, 1'b1, 1'b0, 5'd0, ERR_OK, 4);
        drain("t1_drain", 40);

        // Lowest free slot is 4; confirm arrives 3 cycles after the write
        epoch++;
        busy_stim = 20'h0000F;
        fb_delay  = 3;
        repeat (2) @(posedge clk); #1;
        chk_eq("free_before", free_cnt, 32'd16);
        send(26'h1234567, 1'b0, 1'b1, 5'd4, ERR_OK, 6);
        drain("t2_drain", 40);
        chk_eq("free_after", free_cnt, 32'd15);

        // Array full
        busy_stim = 20'hFFFFF;
        @(posedge clk); #1;
        send(26'h3FFFFFF, 1'b1, 1'b1, 5'd0, ERR_FULL, 2);
        drain("t3_drain", 40);

        // No confirm: timeout after 15 CONFIRM cycles
        epoch++;
        busy_stim = '0;
        fb_delay  = 0;
        @(posedge clk); #1;
        send(26'h0000001, 1'b0, 1'b0, 5'd0, ERR_TIMEOUT, 18);
        drain("t4a_drain", 60);

        // Confirm on the 15th CONFIRM cycle wins over the timeout
        epoch++;
        fb_delay = 15;
        @(posedge clk); #1;
        send(26'h2AAAAAA, 1'b1, 1'b0, 5'd0, ERR_OK, 18);
        drain("t4b_drain", 60);

        // Reset while in CONFIRM: outputs clear at once, no ACK
        epoch++;
        fb_delay = 0;
        @(posedge clk); #1;
        send(26'h1555555, 1'b1, 1'b1, 5'd0, ERR_OK, 18);
        repeat (4) @(posedge clk);
        acks_before = ack_total;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk_eq("abort_no_ack", ack_total - acks_before, 32'd0);
        epoch++;
        fb_delay = 1;
        @(posedge clk); #1;
        send(26'h0C0FFEE, 1'b0, 1'b1, 5'd0, ERR_OK, 4);
        drain("t5_drain", 40);

        // Streaming: REQ_VALID held high for three requests, slot model confirms each
        epoch++;
        fb_delay = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.slot = 5'(i); e.err = ERR_OK; e.lat = 4;
            e.xy = 26'h0246810; e.fire = 1'b1; e.vis = 1'b1;
            exp_q.push_back(e);
        end
        n = hs_total + 3;
        req_valid = 1'b1; req_xy = 26'h0246810; req_fire = 1'b1; req_visible = 1'b1;
        ready_hi = 0;
        for (int c = 0; c < 100 && hs_total < n; c++) begin
            if (req_ready) ready_hi++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk_eq("stream_accepts", hs_total, n);
        chk_eq("stream_ready_cycles", ready_hi, 32'd3);
        drain("t6_drain", 40);
        chk_eq("stream_free", free_cnt, 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
